// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags #(
  parameter int DSIZE        = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [DSIZE-1:0]      wdata,
  input  logic                  rinc,
  output logic [DSIZE-1:0]      rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDRESS_SIZE:0] count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int PW    = ADDRESS_SIZE + 1;
  localparam int DEPTH = 1 << ADDRESS_SIZE;
  if (AEMPTY_LEVEL >= AFULL_LEVEL) begin : g_cfg_err
    $error("sync_fifo_flags: AEMPTY_LEVEL must be below AFULL_LEVEL");
  end
  logic [DSIZE-1:0] mem [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic wfull_q, wfull_d, rempty_q, rempty_d, afull_q, afull_d, aempty_q, aempty_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic wr_acc, rd_acc;
  always_comb begin
    wr_acc      = winc && !wfull_q;
    rd_acc      = rinc && !rempty_q;
    wptr_d      = wr_acc ? wptr_q + PW'(1) : wptr_q;
    rptr_d      = rd_acc ? rptr_q + PW'(1) : rptr_q;
    count_d     = count_q + PW'(wr_acc) - PW'(rd_acc);
    wfull_d     = count_d == PW'(DEPTH);
    rempty_d    = count_d == '0;
    afull_d     = count_d >= PW'(AFULL_LEVEL);
    aempty_d    = count_d <= PW'(AEMPTY_LEVEL);
    overflow_d  = overflow_q | (winc & wfull_q);
    underflow_d = underflow_q | (rinc & rempty_q);
`ifdef SYNC_FIFO_FWFT_EN
    // Next head: nothing left -> hold; only the word being written -> bypass wdata.
    rdata_d = (count_d == '0) ? rdata_q :
              (count_q == PW'(rd_acc)) ? wdata : mem[rptr_d[ADDRESS_SIZE-1:0]];
`else
    rdata_d = rd_acc ? mem[rptr_q[ADDRESS_SIZE-1:0]] : rdata_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      wfull_q     <= 1'b0;
      rempty_q    <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      wfull_q     <= wfull_d;
      rempty_q    <= rempty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wptr_q[ADDRESS_SIZE-1:0]] <= wdata;
  end
  assign rdata        = rdata_q;
  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: queue-model scoreboard plus directed literal checks.
module tb_sync_fifo_flags;
  logic clk = 1'b0, rst = 1'b1, winc = 1'b0, rinc = 1'b0;
  logic [7:0] wdata = '0, rdata;
  logic wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int checks = 0, errors = 0;
  sync_fifo_flags #(.DSIZE(8), .ADDRESS_SIZE(4), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata),
    .wfull(wfull), .rempty(rempty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  logic [7:0] q[$];
  logic [7:0] m_rdata = '0;
  bit m_ov, m_un, mvalid, wa_m, ra_m;
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rdata = '0;
      m_ov = 0;
      m_un = 0;
      mvalid = 1;
    end else begin
      wa_m = winc && q.size() != 16;
      ra_m = rinc && q.size() != 0;
      if (winc && q.size() == 16) m_ov = 1;
      if (rinc && q.size() == 0) m_un = 1;
      if (ra_m) m_rdata = q.pop_front();
      if (wa_m) q.push_back(wdata);
`ifdef SYNC_FIFO_FWFT_EN
      if (q.size() != 0) m_rdata = q[0];
`endif
    end
  end
  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_rempty", 32'(rempty), 32'(q.size() == 0));
      chk("m_wfull", 32'(wfull), 32'(q.size() == 16));
      chk("m_afull", 32'(almost_full), 32'(q.size() >= 12));
      chk("m_aempty", 32'(almost_empty), 32'(q.size() <= 2));
      chk("m_rdata", 32'(rdata), 32'(m_rdata));
      chk("m_ovf", 32'(overflow), 32'(m_ov));
      chk("m_unf", 32'(underflow), 32'(m_un));
    end
  end
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    winc = w;
    wdata = d;
    rinc = r;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc(1'b1, 8'h33, 1'b1);
    rst = 1'b0;
    winc = 1'b0;
    rinc = 1'b0;
  endtask
  initial begin
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_rempty", 32'(rempty), 1);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_err", 32'({overflow, underflow}), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_wfull", 32'(wfull), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      chk("fill_aempty", 32'(almost_empty), 32'(i < 2));
      chk("fill_afull", 32'(almost_full), 32'(i >= 11));
      chk("fill_wfull", 32'(wfull), 32'(i == 15));
    end
    chk("fill_count", 32'(count), 16);
    cyc(1'b1, 8'hAA, 1'b0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("drain_data", 32'(rdata), 32'(i));
      cyc(1'b0, 8'h00, 1'b1);
`else
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_data", 32'(rdata), 32'(i));
`endif
    end
    chk("drain_empty", 32'(rempty), 1);
    chk("drain_unf", 32'(underflow), 0);
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("wrap_data", 32'(rdata), 32'(8'(8'h80 + i)));
      cyc(1'b1, 8'(8'h85 + i), 1'b1);
`else
      cyc(1'b1, 8'(8'h85 + i), 1'b1);
      chk("wrap_data", 32'(rdata), 32'(8'(8'h80 + i)));
`endif
      chk("wrap_count", 32'(count), 5);
    end
    repeat (5) cyc(1'b0, 8'h00, 1'b1);
    chk("wrap_empty", 32'(rempty), 1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    do_reset();
    chk("midrst_count", 32'(count), 0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
    cyc(1'b1, 8'h77, 1'b1);
    chk("full_both_count", 32'(count), 15);
    chk("full_both_ovf", 32'(overflow), 1);
    chk("full_both_unf", 32'(underflow), 0);
    repeat (15) cyc(1'b0, 8'h00, 1'b1);
    chk("pre_empty", 32'(rempty), 1);
    cyc(1'b1, 8'h11, 1'b1);
    chk("empty_both_count", 32'(count), 1);
    chk("empty_both_unf", 32'(underflow), 1);
    cyc(1'b0, 8'h00, 1'b1);
    do_reset();
    cyc(1'b1, 8'h5A, 1'b0);
    chk("fwft_rempty", 32'(rempty), 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_rdata", 32'(rdata), 32'h5A);
`else
    chk("std_rdata_hold", 32'(rdata), 0);
`endif
    cyc(1'b0, 8'h00, 1'b1);
    chk("pop_rempty", 32'(rempty), 1);
    chk("pop_rdata", 32'(rdata), 32'h5A);
    repeat (2) cyc(1'b0, 8'h00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
